ravenoc_link_slice: RTL

- Elastic register stage on a single router-to-router NoC link, inserted between a send port of one router_wrapper and the recv port of its neighbour.
- Breaks long mesh wires with a 2-entry skid FIFO on the clk_noc domain.
- Sustains 1 flit/cycle and has no combinational path from input to output, or from send_ready to recv_ready.
- Checks packet framing on the accepted stream and raises a sticky error flag.

---
 rtl/ravenoc_link_slice.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ravenoc_link_slice.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ravenoc_link_slice: 2-entry elastic skid stage for one NoC link, with a  |
// | framing checker. Optional stats via RAVENOC_LINK_STATS_EN.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module ravenoc_link_slice #(
  parameter int FLIT_WIDTH = 34,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_noc,
  input  logic                  arst_noc,
  input  logic                  recv_valid,
  input  logic [FLIT_WIDTH-1:0] recv_flit,
  output logic                  recv_ready,
  output logic                  send_valid,
  output logic [FLIT_WIDTH-1:0] send_flit,
  input  logic                  send_ready,
  output logic                  frame_err
`ifdef RAVENOC_LINK_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  flit_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
`endif
);

  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_e;

  logic [FLIT_WIDTH-1:0] mem_q [0:1];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  recv_ready_q;
  logic                  send_valid_q;
  logic                  frame_err_q;
  state_e                state_q;
  logic                  w_push, w_pop;
  flit_type_e            w_in_type;

  assign w_push    = recv_valid & recv_ready_q;
  assign w_pop     = send_valid_q & send_ready;
  assign w_in_type = flit_type_e'(recv_flit[FLIT_WIDTH-1 -: 2]);

  always_comb begin
    head_d  = head_q ^ w_pop;
    tail_d  = tail_q ^ w_push;
    count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Ready/valid are decoded from the next count so both leave the stage as flops.
  always_ff @(posedge clk_noc) begin
    if (arst_noc) begin
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      count_q      <= 2'd0;
      recv_ready_q <= 1'b1;
      send_valid_q <= 1'b0;
    end else begin
      if (w_push) mem_q[tail_q] <= recv_flit;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      recv_ready_q <= (count_d != 2'd2);
      send_valid_q <= (count_d != 2'd0);
    end
  end

  always_ff @(posedge clk_noc) begin
    if (arst_noc) begin
      state_q     <= ST_IDLE;
      frame_err_q <= 1'b0;
    end else if (w_push) begin
      case (state_q)
        ST_IDLE: begin
          case (w_in_type)
            FT_HEAD:      state_q <= ST_IN_PKT;
            FT_HEAD_TAIL: state_q <= ST_IDLE;
            default:      frame_err_q <= 1'b1;
          endcase
        end
        default: begin
          case (w_in_type)
            FT_BODY: state_q <= ST_IN_PKT;
            FT_TAIL: state_q <= ST_IDLE;
            FT_HEAD: begin
              frame_err_q <= 1'b1;
              state_q     <= ST_IN_PKT;
            end
            default: begin
              frame_err_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          endcase
        end
      endcase
    end
  end

  assign recv_ready = recv_ready_q;
  assign send_valid = send_valid_q;
  assign send_flit  = mem_q[head_q];
  assign frame_err  = frame_err_q;

`ifdef RAVENOC_LINK_STATS_EN
  logic [CNT_WIDTH-1:0] flit_cnt_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_q;

  // Tail and head_tail both have the top type bit set.
  always_ff @(posedge clk_noc) begin
    if (arst_noc) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (w_pop) begin
      if (flit_cnt_q != '1) flit_cnt_q <= flit_cnt_q + CNT_WIDTH'(1);
      if (send_flit[FLIT_WIDTH-1] && (pkt_cnt_q != '1)) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign flit_cnt = flit_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule
`default_nettype wire
